nbit_rr_stream_mux: RTL and testbench

NBIT_RR_STREAM_MUX -- requirements
Module: nbit_rr_stream_mux

---
 rtl/nbit_rr_stream_mux_pkg.sv | 13 +
 rtl/nbit_rr_stream_mux_picker.sv | 32 +++
 rtl/nbit_rr_stream_mux.sv | 91 +++++++++
 tb/tb_nbit_rr_stream_mux.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/nbit_rr_stream_mux_pkg.sv
// Shared definitions for the round-robin stream multiplexer.
package nbit_rr_stream_mux_pkg;

  localparam logic [1:0] MODE_RR     = 2'b00;
  localparam logic [1:0] MODE_FIXED  = 2'b01;
  localparam logic [1:0] MODE_FORCED = 2'b10;

  // First channel searched after a grant to ptr.
  function automatic int unsigned rr_start(int unsigned ptr, int unsigned m);
    return (ptr + 1) % m;
  endfunction

endpackage

// File: rtl/nbit_rr_stream_mux_picker.sv
// Combinational circular priority picker: first set request at or after start.
module rr_priority_picker
  import nbit_rr_stream_mux_pkg::*;
#(
  parameter int unsigned M = 4,
  localparam int unsigned SW = $clog2(M)
) (
  input  logic [M-1:0]  req,
  input  logic [SW-1:0] start,
  output logic [M-1:0]  grant,
  output logic [SW-1:0] idx,
  output logic          found
);

  logic [SW-1:0] c;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    c     = '0;
    for (int unsigned i = 0; i < M; i++) begin
      c = SW'((32'(start) + i) % M);
      if (!found && req[c]) begin
        found    = 1'b1;
        grant[c] = 1'b1;
        idx      = c;
      end
    end
  end

endmodule

// File: rtl/nbit_rr_stream_mux.sv
// M-channel to one stream multiplexer with round-robin, fixed or forced arbitration
// and a single registered output entry.
module nbit_rr_stream_mux
  import nbit_rr_stream_mux_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned M = 4,
  localparam int unsigned SW = $clog2(M)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [M*N-1:0] in_data,
  input  logic [M-1:0]   in_valid,
  output logic [M-1:0]   in_ready,
  input  logic [1:0]     mode,
  input  logic [SW-1:0]  sel,
  output logic [N-1:0]   out_data,
  output logic [SW-1:0]  out_chan,
  output logic           out_valid,
  input  logic           out_ready
);

  localparam logic [SW-1:0] LastChan = SW'(M - 1);

  logic [N-1:0]  out_data_q;
  logic [SW-1:0] out_chan_q;
  logic          out_valid_q;
  logic [SW-1:0] ptr_q;

  logic          open;
  logic          is_rr;
  logic [M-1:0]  req;
  logic [M-1:0]  grant;
  logic [SW-1:0] start;
  logic [SW-1:0] win_idx;
  logic          found;

  always_comb begin
    req   = in_valid;
    start = '0;
    case (mode)
      MODE_FIXED: ;
      // A sel outside 0..M-1 matches no channel and so never grants.
      MODE_FORCED: begin
        for (int unsigned k = 0; k < M; k++) begin
          req[k] = in_valid[k] && (32'(sel) == k);
        end
      end
      default: start = SW'(rr_start(32'(ptr_q), M));
    endcase
  end

  rr_priority_picker #(
    .M(M)
  ) u_picker (
    .req  (req),
    .start(start),
    .grant(grant),
    .idx  (win_idx),
    .found(found)
  );

  assign open     = !out_valid_q || out_ready;
  assign is_rr    = (mode != MODE_FIXED) && (mode != MODE_FORCED);
  assign in_ready = (open && !rst) ? grant : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= LastChan;
    end else if (open) begin
      if (found) begin
        out_data_q  <= in_data[32'(win_idx)*N +: N];
        out_chan_q  <= win_idx;
        out_valid_q <= 1'b1;
        if (is_rr) begin
          ptr_q <= win_idx;
        end
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_nbit_rr_stream_mux.sv
// Scoreboard bench for nbit_rr_stream_mux: directed scenarios plus random traffic
// against a queue-based behavioural model.
module tb_nbit_rr_stream_mux;

  localparam int N  = 4;
  localparam int M  = 4;
  localparam int SW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [M*N-1:0] in_data;
  logic [M-1:0]   in_valid;
  logic [M-1:0]   in_ready;
  logic [1:0]     mode;
  logic [SW-1:0]  sel;
  logic [N-1:0]   out_data;
  logic [SW-1:0]  out_chan;
  logic           out_valid;
  logic           out_ready;

  nbit_rr_stream_mux #(
    .N(N),
    .M(M)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mode     (mode),
    .sel      (sel),
    .out_data (out_data),
    .out_chan (out_chan),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic [N-1:0]  data;
    logic [SW-1:0] chan;
  } entry_t;

  entry_t exp_q[$];
  bit     m_valid;
  int     m_ptr;
  bit     m_open;
  int     m_win;
  entry_t mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Winner by the arbitration rules; -1 when nobody wins.
  function automatic int pick(input logic [1:0] md, input logic [SW-1:0] s,
                              input logic [M-1:0] v, input int p);
    if (md == 2'b01) begin
      for (int i = 0; i < M; i++) if (v[i]) return i;
      return -1;
    end
    if (md == 2'b10) begin
      if (int'(s) < M && v[s]) return int'(s);
      return -1;
    end
    for (int k = 1; k <= M; k++) if (v[(p + k) % M]) return (p + k) % M;
    return -1;
  endfunction

  // Reference model: inputs are stable at the falling edge, so predict the next rising edge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_valid = 1'b0;
      m_ptr   = M - 1;
      check("in_ready_in_reset", 32'(in_ready), 32'd0);
    end else begin
      m_open = !m_valid || out_ready;
      m_win  = m_open ? pick(mode, sel, in_valid, m_ptr) : -1;
      check("out_valid", 32'(out_valid), 32'(m_valid));
      check("in_ready", 32'(in_ready), (m_win >= 0) ? (32'd1 << m_win) : 32'd0);
      if (m_open) begin
        if (m_win >= 0) begin
          exp_q.push_back({in_data[m_win*N +: N], SW'(m_win)});
          m_valid = 1'b1;
          if (mode != 2'b01 && mode != 2'b10) m_ptr = m_win;
        end else begin
          m_valid = 1'b0;
        end
      end
    end
  end

  // Monitor: every output transfer must match the oldest predicted entry.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_data", 32'(out_data), 32'(mon_e.data));
        check("out_chan", 32'(out_chan), 32'(mon_e.chan));
      end
    end
  end

  task automatic cyc(input logic [M-1:0] v, input logic [1:0] md, input logic [SW-1:0] s,
                     input logic ordy, input logic [M*N-1:0] d);
    in_valid  = v;
    mode      = md;
    sel       = s;
    out_ready = ordy;
    in_data   = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = '1;
    in_data   = '0;
    mode      = 2'b00;
    sel       = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_data", 32'(out_data), 32'd0);
    check("reset_out_chan", 32'(out_chan), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;

    // Round-robin fairness from reset: 0,1,2,3,0,1,2,3.
    repeat (8) cyc(4'b1111, 2'b00, 2'd0, 1'b1, 16'($urandom));
    // Backpressure then release.
    repeat (3) cyc(4'b0110, 2'b00, 2'd0, 1'b0, 16'($urandom));
    cyc(4'b0110, 2'b00, 2'd0, 1'b1, 16'($urandom));
    // Fixed priority starves channel 3.
    repeat (3) cyc(4'b1010, 2'b01, 2'd0, 1'b1, 16'($urandom));
    // Forced select.
    cyc(4'b0100, 2'b10, 2'd2, 1'b1, 16'h0A00);
    check("forced_data", 32'(out_data), 32'hA);
    check("forced_chan", 32'(out_chan), 32'd2);
    cyc(4'b1011, 2'b10, 2'd2, 1'b1, 16'($urandom));
    check("forced_no_grant", 32'(out_valid), 32'd0);
    // Wrap: grant 3, then 0, then 3.
    cyc(4'b1000, 2'b00, 2'd0, 1'b1, 16'($urandom));
    repeat (2) cyc(4'b1001, 2'b00, 2'd0, 1'b1, 16'($urandom));
    check("wrap_chan", 32'(out_chan), 32'd3);
    // Reset while holding an entry.
    cyc(4'b1111, 2'b11, 2'd0, 1'b0, 16'($urandom));
    rst = 1'b1;
    #1;
    check("midreset_out_valid", 32'(out_valid), 32'd0);
    check("midreset_out_data", 32'(out_data), 32'd0);
    check("midreset_out_chan", 32'(out_chan), 32'd0);
    check("midreset_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Random traffic, all modes, occasional reset.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
      end
      cyc(M'($urandom), 2'($urandom), SW'($urandom), ($urandom_range(0, 9) < 7),
          16'($urandom));
    end

    repeat (3) cyc(4'b0000, 2'b00, 2'd0, 1'b1, 16'($urandom));
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
